nibble_serial_adder: RTL

- Multi-cycle WIDTH-bit adder/subtractor built on a 4-bit carry-lookahead slice (p/g generate/propagate form) with carry-in.
- Processes one nibble per clock, LSB nibble first, and registers the carry between nibbles.
- Sits upstream of wide-arithmetic consumers and uses a valid/ready handshake on both sides.
- Adds carry-in and subtract support on top of the team's fixed-zero-carry 4-bit adder.

---
 rtl/nibble_serial_adder_if.sv | 29 ++
 rtl/nibble_serial_adder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Handshake bundle for nibble_serial_adder.
//   Upstream side : in_valid, in_ready, a, b, sub
//   Downstream side: out_valid, out_ready, sum, cout, overflow
//   master modport is the producer/consumer environment; slave is the adder.
interface nibble_serial_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. Operands are captured on an
//   input handshake, then one nibble (LSB first) is added per clock through a
//   4-bit carry-lookahead slice, with the carry registered between nibbles.
//   The result is offered on an output handshake and held until taken.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - nibble_serial_adder_if.slave:
//           in_valid/in_ready/a/b/sub   operand handshake (sub=1 -> a-b)
//           out_valid/out_ready/sum/cout/overflow  result handshake
//           cout: carry out of MSB (subtract: 1 = no borrow)
//           overflow: signed overflow
module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nibble_serial_adder_if.slave bus
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [3:0]       nib_a, nib_b, nib_g, nib_p, nib_s;
   logic [4:0]       nib_c;

   // Current nibble operands, selected by idx_q.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int unsigned n = 0; n < NIB; n++) begin
         if (idx_q == IDXW'(n)) begin
            nib_a = a_q[4*n +: 4];
            nib_b = b_q[4*n +: 4];
         end
      end
   end

   // 4-bit carry-lookahead slice; nib_c[3] is the carry into the slice MSB,
   // which on the last nibble is the carry into bit WIDTH-1.
   always_comb begin
      nib_g    = nib_a & nib_b;
      nib_p    = nib_a ^ nib_b;
      nib_c[0] = carry_q;
      nib_c[1] = nib_g[0] | (nib_p[0] & nib_c[0]);
      nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0])
               | (nib_p[1] & nib_p[0] & nib_c[0]);
      nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1])
               | (nib_p[2] & nib_p[1] & nib_g[0])
               | (nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
      nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2])
               | (nib_p[3] & nib_p[2] & nib_g[1])
               | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
               | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
      nib_s    = nib_p ^ nib_c[3:0];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               // Subtraction as a + ~b + 1: invert b here, seed carry with 1.
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int unsigned n = 0; n < NIB; n++) begin
               if (idx_q == IDXW'(n)) begin
                  sum_d[4*n +: 4] = nib_s;
               end
            end
            carry_d = nib_c[4];
            if (idx_q == IDXW'(NIB - 1)) begin
               cout_d  = nib_c[4];
               ovf_d   = nib_c[3] ^ nib_c[4];
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // in_ready is gated by rst_n so nothing is accepted while held in reset.
   assign bus.in_ready  = rst_n && (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;

endmodule
